// File: rtl/ysyx_23060077_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// encodings and the helpers that decide which funct3 values are legal.
package ysyx_23060077_lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_ADDR_WIDTH = 32;
  localparam int STRB_WIDTH     = LSU_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/ysyx_23060077_lsu_if.sv
// Memory request/response bus between the LSU (master) and memory (slave).
interface ysyx_23060077_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_wen;
  logic [ADDR_WIDTH-1:0]     mem_req_addr;
  logic [DATA_WIDTH-1:0]     mem_req_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_req_wstrb;
  logic                      mem_rsp_valid;
  logic                      mem_rsp_ready;
  logic [DATA_WIDTH-1:0]     mem_rsp_rdata;
  logic                      mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/ysyx_23060077_lsu_align.sv
// Combinational datapath of the LSU: store lane replication and strobes,
// load shift/extend, and detection of illegal or misaligned accesses.
module ysyx_23060077_lsu_align
  import ysyx_23060077_lsu_pkg::*;
(
  input  logic [1:0]                off,
  input  logic [2:0]                funct3,
  input  logic                      mem_ren,
  input  logic                      mem_wen,
  input  logic [LSU_DATA_WIDTH-1:0] store_data,
  input  logic [LSU_DATA_WIDTH-1:0] rdata,
  output logic [LSU_DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0]     wstrb,
  output logic [LSU_DATA_WIDTH-1:0] load_data,
  output logic                      err
);

  logic                      misaligned;
  logic [LSU_DATA_WIDTH-1:0] shifted;

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    misaligned = 1'b0;
    if (funct3[1:0] == 2'b01) misaligned = off[0];
    if (funct3[1:0] == 2'b10) misaligned = (off != 2'b00);
  end

  always_comb begin
    err = 1'b0;
    if (mem_ren && mem_wen)
      err = 1'b1;
    else if (mem_ren)
      err = !load_f3_legal(funct3) || misaligned;
    else if (mem_wen)
      err = !store_f3_legal(funct3) || misaligned;
  end

  always_comb begin
    wdata = '0;
    wstrb = '0;
    if (mem_wen && !mem_ren) begin
      case (funct3)
        F3_SB: begin
          wstrb = 4'b0001 << off;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          wstrb = 4'b0011 << off;
          wdata = {2{store_data[15:0]}};
        end
        F3_SW: begin
          wstrb = 4'b1111;
          wdata = store_data;
        end
        default: ;
      endcase
    end
  end

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data = shifted;
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060077_lsu.sv
// Load/store stage: accepts one execute result, issues at most one memory
// transaction for it, and presents aligned write-back data to WB.
module ysyx_23060077_lsu
  import ysyx_23060077_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] exu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd_addr,
  input  logic                  reg_wen,
  ysyx_23060077_lsu_if.master   mem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wb_data,
  output logic [4:0]            out_rd_addr,
  output logic                  out_reg_wen,
  output logic                  out_err
);

  lsu_state_e              state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    wen_q;
  logic [2:0]              funct3_q;
  logic [4:0]              rd_q;
  logic                    reg_wen_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;
  logic                    err_q;

  logic [1:0]              al_off;
  logic [2:0]              al_funct3;
  logic [DATA_WIDTH-1:0]   al_wdata;
  logic [STRB_WIDTH-1:0]   al_wstrb;
  logic [DATA_WIDTH-1:0]   al_load;
  logic                    al_err;

  // The aligner classifies live inputs in IDLE and extracts loads from latched fields later
  assign al_off    = (state == LSU_IDLE) ? exu_result[1:0] : addr_q[1:0];
  assign al_funct3 = (state == LSU_IDLE) ? funct3 : funct3_q;

  ysyx_23060077_lsu_align u_align (
    .off        (al_off),
    .funct3     (al_funct3),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .store_data (store_data),
    .rdata      (mem.mem_rsp_rdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_data  (al_load),
    .err        (al_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LSU_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wen_q     <= 1'b0;
      funct3_q  <= '0;
      rd_q      <= '0;
      reg_wen_q <= 1'b0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (in_valid) begin
            addr_q    <= exu_result;
            wdata_q   <= al_wdata;
            wstrb_q   <= al_wstrb;
            wen_q     <= mem_wen;
            funct3_q  <= funct3;
            rd_q      <= rd_addr;
            reg_wen_q <= reg_wen;
            if (!mem_ren && !mem_wen) begin
              wb_data_q <= exu_result;
              err_q     <= 1'b0;
              state     <= LSU_DONE;
            end else if (al_err) begin
              wb_data_q <= '0;
              err_q     <= 1'b1;
              state     <= LSU_DONE;
            end else begin
              wb_data_q <= '0;
              err_q     <= 1'b0;
              state     <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (mem.mem_req_ready) state <= LSU_WAIT;
        end
        LSU_WAIT: begin
          if (mem.mem_rsp_valid) begin
            state <= LSU_DONE;
            if (mem.mem_rsp_err) begin
              err_q     <= 1'b1;
              wb_data_q <= '0;
            end else begin
              wb_data_q <= wen_q ? '0 : al_load;
            end
          end
        end
        LSU_DONE: begin
          if (out_ready) state <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  assign in_ready           = (state == LSU_IDLE);
  assign mem.mem_req_valid  = (state == LSU_REQ);
  assign mem.mem_rsp_ready  = (state == LSU_WAIT);
  assign mem.mem_req_wen    = wen_q;
  assign mem.mem_req_addr   = addr_q;
  assign mem.mem_req_wdata  = wdata_q;
  assign mem.mem_req_wstrb  = wstrb_q;

  assign out_valid   = (state == LSU_DONE);
  assign out_wb_data = wb_data_q;
  assign out_rd_addr = rd_q;
  assign out_reg_wen = reg_wen_q & ~err_q;
  assign out_err     = err_q;

endmodule
